// File: rtl/kyber_pkg.sv
// Shared constants and types for the Kyber matrix-generation datapath.
// Widths here are fixed by the Kyber polynomial format (256 x 12-bit coefficients).
package kyber_pkg;

  localparam int KYBER_K        = 3;
  localparam int KYBER_N        = 256;
  localparam int COEFF_W        = 12;
  localparam int NBEAT_DEF      = 96;
  localparam int XOF_W          = 64;
  localparam int CWORD_W        = 48;
  localparam int LANES          = CWORD_W / COEFF_W;
  localparam int WORDS_PER_POLY = KYBER_N / LANES;
  localparam int IDX_W          = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_STREAM,
    ST_DRAIN,
    ST_NEXT,
    ST_FIN
  } state_t;

  // Byte order of the two appended XOF index bytes: {[15:8], [7:0]}.
  function automatic logic [IDX_W-1:0] fmt_idx(input logic [7:0] row,
                                               input logic [7:0] col,
                                               input logic       transpose);
    return transpose ? {row, col} : {col, row};
  endfunction

endpackage

// File: rtl/gen_matrix_ctrl_if.sv
// Bundle of the start/status, XOF, parse and coefficient-RAM signals of gen_matrix_ctrl.
// The master side is the controller; the slave side is its surrounding datapath.
interface gen_matrix_ctrl_if #(
  parameter int AW = 10
) ();

  logic                         i_start;
  logic                         i_transpose;
  logic                         o_busy;
  logic                         o_done;
  logic                         o_err;

  logic                         o_xof_req;
  logic [kyber_pkg::IDX_W-1:0]  o_xof_idx;
  logic [kyber_pkg::XOF_W-1:0]  i_xof_data;
  logic                         i_xof_valid;
  logic                         o_xof_ready;

  logic [kyber_pkg::XOF_W-1:0]  o_parse_bytes;
  logic                         o_parse_valid;
  logic [kyber_pkg::CWORD_W-1:0] i_parse_coeffs;
  logic                         i_parse_coeffs_valid;
  logic                         i_parse_done;

  logic                         o_mem_we;
  logic [AW-1:0]                o_mem_addr;
  logic [kyber_pkg::CWORD_W-1:0] o_mem_wdata;

  modport master (
    input  i_start, i_transpose,
    output o_busy, o_done, o_err,
    output o_xof_req, o_xof_idx, o_xof_ready,
    input  i_xof_data, i_xof_valid,
    output o_parse_bytes, o_parse_valid,
    input  i_parse_coeffs, i_parse_coeffs_valid, i_parse_done,
    output o_mem_we, o_mem_addr, o_mem_wdata
  );

  modport slave (
    output i_start, i_transpose,
    input  o_busy, o_done, o_err,
    input  o_xof_req, o_xof_idx, o_xof_ready,
    output i_xof_data, i_xof_valid,
    input  o_parse_bytes, o_parse_valid,
    output i_parse_coeffs, i_parse_coeffs_valid, i_parse_done,
    input  o_mem_we, o_mem_addr, o_mem_wdata
  );

endinterface

// File: rtl/gen_matrix_idx.sv
// Row-major (i outer, j inner) walker over the K x K matrix entries, with
// last-entry flag, linear entry number and transpose-aware XOF index bytes.
module gen_matrix_idx import kyber_pkg::*; #(
  parameter int K  = KYBER_K,
  parameter int EW = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             clear,
  input  logic             advance,
  input  logic             transpose,
  output logic [IDX_W-1:0] idx,
  output logic             last,
  output logic [EW-1:0]    entry
);

  localparam int CW = (K > 1) ? $clog2(K) : 1;

  logic [CW-1:0] row_reg;
  logic [CW-1:0] col_reg;
  logic [EW-1:0] entry_reg;
  logic          transpose_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      row_reg       <= '0;
      col_reg       <= '0;
      entry_reg     <= '0;
      transpose_reg <= 1'b0;
    end else if (clear) begin
      row_reg       <= '0;
      col_reg       <= '0;
      entry_reg     <= '0;
      transpose_reg <= transpose;
    end else if (advance) begin
      if (col_reg == CW'(K - 1)) begin
        col_reg <= '0;
        row_reg <= row_reg + CW'(1);
      end else begin
        col_reg <= col_reg + CW'(1);
      end
      entry_reg <= entry_reg + EW'(1);
    end
  end

  assign last  = (row_reg == CW'(K - 1)) && (col_reg == CW'(K - 1));
  assign idx   = fmt_idx(8'(row_reg), 8'(col_reg), transpose_reg);
  assign entry = entry_reg;

endmodule

// File: rtl/gen_matrix_ctrl.sv
// Sequencer for the parse rejection sampler: one XOF request per matrix entry,
// NBEAT squeeze words forwarded to parse, 64 coefficient words written to RAM.
module gen_matrix_ctrl import kyber_pkg::*; #(
  parameter int K         = KYBER_K,
  parameter int NBEAT     = NBEAT_DEF,
  parameter int DRAIN_MAX = 255,
  parameter int AW        = $clog2(K * K * WORDS_PER_POLY)
) (
  input logic              i_clk,
  input logic              i_rst,
  gen_matrix_ctrl_if.master bus
);

  localparam int BW = $clog2(NBEAT + 1);
  localparam int WW = $clog2(WORDS_PER_POLY + 1);
  localparam int OW = $clog2(WORDS_PER_POLY);
  localparam int DW = $clog2(DRAIN_MAX + 1);
  localparam int EW = AW - OW;

  state_t              state_reg;
  state_t              state_next;
  logic [BW-1:0]       beat_cnt_reg;
  logic [WW-1:0]       word_cnt_reg;
  logic [DW-1:0]       drain_cnt_reg;
  logic                err_reg;
  logic [XOF_W-1:0]    parse_bytes_reg;
  logic                parse_valid_reg;
  logic                mem_we_reg;
  logic [AW-1:0]       mem_addr_reg;
  logic [CWORD_W-1:0]  wdata_bits;

  logic                idx_clear;
  logic                idx_advance;
  logic                idx_last;
  logic [IDX_W-1:0]    idx_w;
  logic [EW-1:0]       entry_w;

  logic                start_accept;
  logic                xof_ready;
  logic                xof_hs;
  logic                capture_phase;
  logic                coeff_accept;
  logic                coeff_overflow;
  logic [WW-1:0]       words_seen;
  logic                err_set;

  gen_matrix_idx #(
    .K  (K),
    .EW (EW)
  ) u_idx (
    .clk       (i_clk),
    .srst      (i_rst),
    .clear     (idx_clear),
    .advance   (idx_advance),
    .transpose (bus.i_transpose),
    .idx       (idx_w),
    .last      (idx_last),
    .entry     (entry_w)
  );

  assign start_accept   = (state_reg == ST_IDLE) && bus.i_start;
  assign xof_ready      = (state_reg == ST_STREAM) && (beat_cnt_reg < BW'(NBEAT));
  assign xof_hs         = xof_ready && bus.i_xof_valid;
  assign capture_phase  = (state_reg == ST_STREAM) || (state_reg == ST_DRAIN);
  assign coeff_accept   = capture_phase && bus.i_parse_coeffs_valid &&
                          (word_cnt_reg < WW'(WORDS_PER_POLY));
  assign coeff_overflow = capture_phase && bus.i_parse_coeffs_valid &&
                          (word_cnt_reg == WW'(WORDS_PER_POLY));
  // A word arriving together with parse_done still counts toward the entry.
  assign words_seen     = word_cnt_reg + WW'(coeff_accept);

  always_comb begin
    state_next  = state_reg;
    idx_clear   = 1'b0;
    idx_advance = 1'b0;
    err_set     = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (bus.i_start) begin
          idx_clear  = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        state_next = ST_STREAM;
      end
      ST_STREAM: begin
        if (bus.i_parse_done) begin
          err_set = 1'b1;
        end
        if (xof_hs && (beat_cnt_reg == BW'(NBEAT - 1))) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bus.i_parse_done) begin
          err_set    = (words_seen != WW'(WORDS_PER_POLY));
          state_next = ST_NEXT;
        end else if (drain_cnt_reg == DW'(DRAIN_MAX)) begin
          err_set    = 1'b1;
          state_next = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (idx_last) begin
          state_next = ST_FIN;
        end else begin
          idx_advance = 1'b1;
          state_next  = ST_REQ;
        end
      end
      ST_FIN: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      beat_cnt_reg  <= '0;
      word_cnt_reg  <= '0;
      drain_cnt_reg <= '0;
    end else begin
      if (state_reg == ST_REQ) begin
        beat_cnt_reg <= '0;
        word_cnt_reg <= '0;
      end else begin
        if (xof_hs) begin
          beat_cnt_reg <= beat_cnt_reg + BW'(1);
        end
        if (coeff_accept) begin
          word_cnt_reg <= word_cnt_reg + WW'(1);
        end
      end
      if (state_reg != ST_DRAIN) begin
        drain_cnt_reg <= '0;
      end else if (drain_cnt_reg != DW'(DRAIN_MAX)) begin
        drain_cnt_reg <= drain_cnt_reg + DW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_reg <= 1'b0;
    end else if (start_accept) begin
      err_reg <= 1'b0;
    end else if (err_set || coeff_overflow) begin
      err_reg <= 1'b1;
    end
  end

  // XOF words pass through one register; idle beats are forced to zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      parse_valid_reg <= 1'b0;
      parse_bytes_reg <= '0;
    end else begin
      parse_valid_reg <= xof_hs;
      parse_bytes_reg <= xof_hs ? bus.i_xof_data : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mem_we_reg   <= 1'b0;
      mem_addr_reg <= '0;
    end else begin
      mem_we_reg <= coeff_accept;
      if (coeff_accept) begin
        mem_addr_reg <= {entry_w, word_cnt_reg[OW-1:0]};
      end
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [COEFF_W-1:0] lane_reg;
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        lane_reg <= '0;
      end else if (coeff_accept) begin
        lane_reg <= bus.i_parse_coeffs[gi*COEFF_W +: COEFF_W];
      end
    end
    assign wdata_bits[gi*COEFF_W +: COEFF_W] = lane_reg;
  end

  assign bus.o_busy        = (state_reg == ST_REQ) || (state_reg == ST_STREAM) ||
                             (state_reg == ST_DRAIN) || (state_reg == ST_NEXT);
  assign bus.o_done        = (state_reg == ST_FIN);
  assign bus.o_err         = err_reg;
  assign bus.o_xof_req     = (state_reg == ST_REQ);
  assign bus.o_xof_idx     = idx_w;
  assign bus.o_xof_ready   = xof_ready;
  assign bus.o_parse_bytes = parse_bytes_reg;
  assign bus.o_parse_valid = parse_valid_reg;
  assign bus.o_mem_we      = mem_we_reg;
  assign bus.o_mem_addr    = mem_addr_reg;
  assign bus.o_mem_wdata   = wdata_bits;

endmodule

// File: doc/gen_matrix_ctrl.md
# gen_matrix_ctrl

Sequencing controller for the `parse` rejection-sampling block during Kyber matrix generation. It walks all K×K entries of Â and issues one XOF request per entry with index bytes (i,j) or (j,i). It streams 96 × 64-bit XOF words (768 bytes) into `parse` and writes the 256 accepted 12-bit coefficients (64 × 48-bit words) into polynomial RAM. It sits between the XOF/Keccak squeeze interface and the NTT-domain coefficient memory.

## Interface
- K, default 3: module rank (2, 3 or 4); entries = K*K.
- NBEAT, default 96: 64-bit words streamed to `parse` per entry.
- DRAIN_MAX, default 255: max cycles to wait for `i_parse_done` after the last beat.
- AW, default $clog2(K*K*64): memory address width.

Ports:
- i_clk  in  1  clock; all logic rising-edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  start pulse; sampled only in IDLE.
- i_transpose  in  1  0: index = (j,i); 1: index = (i,j). Latched at start.
- o_busy  out  1  high from the cycle after start acceptance until o_done.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  sticky error, cleared on next accepted start.
- o_xof_req  out  1  one-cycle pulse per entry.
- o_xof_idx  out  16  [7:0] first appended byte, [15:8] second; held stable until the next request.
- i_xof_data  in  64  XOF squeeze word.
- i_xof_valid  in  1  XOF word valid.
- o_xof_ready  out  1  controller accepts the word.
- o_parse_bytes  out  64  word to `parse`; 0 when not valid.
- o_parse_valid  out  1  beat valid to `parse`.
- i_parse_coeffs  in  48  4 coefficients from `parse`.
- i_parse_coeffs_valid  in  1  coefficient word valid.
- i_parse_done  in  1  `parse` finished the current entry.
- o_mem_we  out  1  coefficient RAM write enable.
- o_mem_addr  out  AW  entry*64 + word index.
- o_mem_wdata  out  48  registered copy of i_parse_coeffs.

## Operation
- FSM states: IDLE → REQ → STREAM → DRAIN → NEXT → (REQ | FIN) → IDLE.
- **IDLE:** if i_start, latch i_transpose, clear o_err, set i=j=0, go REQ. i_start in any other state is ignored.
- **REQ:** o_xof_req=1 for one cycle; o_xof_idx loaded per transpose; beat_cnt=0, word_cnt=0; go STREAM.
- **STREAM:**
  - o_xof_ready = (beat_cnt < NBEAT).
  - Each i_xof_valid && o_xof_ready handshake registers the data into o_parse_bytes, asserts o_parse_valid the next cycle and increments beat_cnt.
  - XOF gaps produce o_parse_valid gaps (`parse` stalls).
  - Once beat_cnt reaches NBEAT, go DRAIN.
- **Coefficient capture (STREAM and DRAIN):**
  - Each i_parse_coeffs_valid with word_cnt<64 registers a RAM write and increments word_cnt.
  - Words with word_cnt==64 are dropped and set o_err.
- **DRAIN:** wait for i_parse_done, with timer limit DRAIN_MAX.
  - On i_parse_done: set o_err if word_cnt≠64, then go NEXT.
  - On timeout: set o_err, go NEXT.
  - i_parse_done seen during STREAM sets o_err; the FSM still finishes the beats.
- **NEXT:** advance row-major (j inner, i outer). If i=K-1 and j=K-1, go FIN; else go REQ.
- **FIN:** o_done=1 for one cycle, o_busy drops the same cycle, go IDLE.
- **Reset:** i_rst in any state (mid-operation included) returns to IDLE within one edge and zeroes all outputs. RAM contents are untouched.
- **Reset values:** all outputs 0, including o_xof_idx, o_mem_addr and o_err.

## Timing
- Start accepted at edge T; o_busy=1 and state=REQ at T+1; o_xof_req at T+1; first o_xof_ready at T+2.
- XOF handshake at edge E → o_parse_valid/o_parse_bytes at E+1 (1-cycle latency).
- i_parse_coeffs_valid at edge E → o_mem_we/addr/wdata at E+1.
- Per-entry overhead with no XOF gaps: REQ 1 + NBEAT + drain + NEXT 1 cycles.
- The last coefficient write of the final entry is issued no later than the o_done cycle.

## Structure
- Shared package `kyber_pkg`: K, N=256, coefficient width 12, NBEAT=96, coefficient word width 48, FSM state encoding.
- Natural sub-module `gen_matrix_idx`: the (i,j) row-major counter with last-entry flag and transpose-aware index formatting.
- `parse` is instantiated by the parent, not inside this block.

## Test plan
- **Normal run:** K=2, transpose=0, gap-free XOF, behavioural `parse` model emitting 64 words per entry → 4 o_xof_req pulses with idx 0x0000, 0x0100, 0x0001, 0x0101; 256 writes at addr 0..255; one o_done; o_err=0.
- **Transpose:** K=3, transpose=1 → idx sequence 0x0000, 0x0001, 0x0002, 0x0100 … 0x0202; RAM contents match the golden vectors from ../vec/parse.
- **XOF gaps:** random i_xof_valid at 30 % duty → exactly 96 handshakes per entry, o_parse_bytes order preserved, results identical to the gap-free run.
- **Short output:** `parse` model emits 63 words then done → o_err=1, FSM advances to the next entry.
- **Overflow output:** model emits 65 words → 65th word not written, o_err=1.
- **Reset and start rules:** i_rst asserted at beat 40 of entry 1 → next cycle all outputs 0 and state IDLE. A new i_start then runs cleanly from entry 0. i_start pulsed while busy is ignored (exactly one o_done).
